// File: rtl/timekeeper_ctrl.sv
// Time-of-day clock with set modes and a timed alarm; all outputs come straight from registers.
// Ring counter holds the remaining TICKs of an active alarm.
module timekeeper_ctrl #(
   parameter int unsigned ALARM_LEN = 60
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       TICK,
   input  logic       MODE_BTN,
   input  logic       INC_BTN,
   input  logic       ALARM_EN,
   output logic [5:0] Hours,
   output logic [5:0] Mins,
   output logic [5:0] Secs,
   output logic [5:0] AlarmH,
   output logic [5:0] AlarmM,
   output logic [2:0] Mode,
   output logic       Alarm
);

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      SET_AH = 3'd3,
      SET_AM = 3'd4
   } mode_t;

   mode_t       state_q, state_d;
   logic [5:0]  hours_q, hours_d, mins_q, mins_d, secs_q, secs_d;
   logic [5:0]  alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d;
   logic        alarm_q, alarm_d;
   logic [7:0]  ring_q, ring_d;
   logic [5:0]  hours_t, mins_t, secs_t;
   logic        inc, tick_adv, match;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= RUN;
         hours_q   <= 6'd0;
         mins_q    <= 6'd0;
         secs_q    <= 6'd0;
         alarm_h_q <= 6'd6;
         alarm_m_q <= 6'd0;
         alarm_q   <= 1'b0;
         ring_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         hours_q   <= hours_d;
         mins_q    <= mins_d;
         secs_q    <= secs_d;
         alarm_h_q <= alarm_h_d;
         alarm_m_q <= alarm_m_d;
         alarm_q   <= alarm_d;
         ring_q    <= ring_d;
      end
   end

   always_comb begin
      // MODE_BTN has priority over INC_BTN in the same cycle
      inc      = INC_BTN & ~MODE_BTN;
      tick_adv = TICK & ((state_q == RUN) | (state_q == SET_AH) | (state_q == SET_AM));

      hours_t = hours_q;
      mins_t  = mins_q;
      secs_t  = secs_q;
      if (tick_adv) begin
         if (secs_q == 6'd59) begin
            secs_t = 6'd0;
            if (mins_q == 6'd59) begin
               mins_t  = 6'd0;
               hours_t = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
            end else begin
               mins_t = mins_q + 6'd1;
            end
         end else begin
            secs_t = secs_q + 6'd1;
         end
      end

      // Only a TICK can produce a match; set-mode increments never do
      match = tick_adv & ALARM_EN & (hours_t == alarm_h_q) & (mins_t == alarm_m_q)
              & (secs_t == 6'd0);

      state_d   = state_q;
      hours_d   = hours_t;
      mins_d    = mins_t;
      secs_d    = secs_t;
      alarm_h_d = alarm_h_q;
      alarm_m_d = alarm_m_q;

      case (state_q)
         RUN: begin
            if (MODE_BTN) begin
               state_d = SET_H;
               secs_d  = 6'd0;
            end
         end
         SET_H: begin
            if (MODE_BTN) state_d = SET_M;
            else if (inc) hours_d = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
         end
         SET_M: begin
            if (MODE_BTN) state_d = SET_AH;
            else if (inc) mins_d = (mins_q == 6'd59) ? 6'd0 : mins_q + 6'd1;
         end
         SET_AH: begin
            if (MODE_BTN) state_d = SET_AM;
            else if (inc) alarm_h_d = (alarm_h_q == 6'd23) ? 6'd0 : alarm_h_q + 6'd1;
         end
         SET_AM: begin
            if (MODE_BTN) state_d = RUN;
            else if (inc) alarm_m_d = (alarm_m_q == 6'd59) ? 6'd0 : alarm_m_q + 6'd1;
         end
         default: state_d = RUN;
      endcase

      alarm_d = alarm_q;
      ring_d  = ring_q;
      if (!ALARM_EN || (inc && state_q == RUN)) begin
         alarm_d = 1'b0;
         ring_d  = 8'd0;
      end else if (match) begin
         alarm_d = 1'b1;
         ring_d  = 8'(ALARM_LEN);
      end else if (alarm_q && TICK) begin
         ring_d = ring_q - 8'd1;
         if (ring_q == 8'd1) alarm_d = 1'b0;
      end
   end

   assign Hours  = hours_q;
   assign Mins   = mins_q;
   assign Secs   = secs_q;
   assign AlarmH = alarm_h_q;
   assign AlarmM = alarm_m_q;
   assign Mode   = state_q;
   assign Alarm  = alarm_q;

endmodule

// File: doc/timekeeper_ctrl.md
TIMEKEEPER_CTRL -- requirements
Module: timekeeper_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ALARM_LEN, default 60, the number of TICKs Alarm stays asserted (range 1..255).
Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port CLK, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port TICK, input, 1 bit: one-cycle 1-second enable strobe.
REQ-005 The block SHALL have port MODE_BTN, input, 1 bit: debounced one-cycle pulse that advances the mode.
REQ-006 The block SHALL have port INC_BTN, input, 1 bit: debounced one-cycle pulse that increments the selected field or dismisses the alarm.
REQ-007 The block SHALL have port ALARM_EN, input, 1 bit: level alarm arm.
REQ-008 The block SHALL have ports Hours, Mins and Secs, outputs, 6 bits each: time of day, binary.
REQ-009 The block SHALL have ports AlarmH and AlarmM, outputs, 6 bits each: alarm time.
REQ-010 The block SHALL have port Mode, output, 3 bits: state, RUN=0, SET_H=1, SET_M=2, SET_AH=3, SET_AM=4.
REQ-011 The block SHALL have port Alarm, output, 1 bit: alarm active, registered.

Function
REQ-012 The FSM SHALL step RUN->SET_H->SET_M->SET_AH->SET_AM->RUN on each MODE_BTN pulse; encodings 5..7 SHALL go to RUN on the next edge.
REQ-013 In RUN, SET_AH and SET_AM, each TICK SHALL advance time: Secs 59->0 with Mins+1, Mins 59 (with Secs 59)->0 with Hours+1, 23:59:59->00:00:00.
REQ-014 In SET_H and SET_M, TICK SHALL be ignored and time SHALL not advance.
REQ-015 The RUN->SET_H transition SHALL clear Secs to 0 on the same edge.
REQ-016 INC_BTN in SET_H SHALL increment Hours with 23->0 wrap, with no effect on Mins.
REQ-017 INC_BTN in SET_M SHALL increment Mins with 59->0 wrap, with no carry into Hours.
REQ-018 INC_BTN in SET_AH and SET_AM SHALL increment AlarmH (23->0) and AlarmM (59->0) respectively.
REQ-019 When MODE_BTN and INC_BTN are both high in one cycle, MODE_BTN SHALL win and INC_BTN SHALL be ignored.
REQ-020 When TICK and INC_BTN are both high in a set-alarm mode, both SHALL take effect on the same edge.
REQ-021 A match event SHALL occur on the edge where a TICK updates time to exactly AlarmH:AlarmM:00 while ALARM_EN=1.
REQ-022 A match event SHALL set Alarm=1 on that edge and load an 8-bit ring counter with ALARM_LEN.
REQ-023 While Alarm=1, each TICK SHALL decrement the ring counter, and Alarm SHALL clear on the edge the counter goes from 1 to 0.
REQ-024 Alarm SHALL clear on the next edge when ALARM_EN=0.
REQ-025 Alarm SHALL clear on the next edge when INC_BTN is pulsed in RUN; that INC_BTN SHALL have no other effect.
REQ-026 Time values reached by set-mode increments SHALL NOT create a match event.
REQ-027 A match event while Alarm=1 SHALL reload the ring counter.
REQ-028 The block SHALL have no combinational path from input to output.

Reset
REQ-029 While RST=1, the block SHALL force Mode=RUN, Hours/Mins/Secs=0, AlarmH=6, AlarmM=0, Alarm=0 and ring counter=0, regardless of CLK.
REQ-030 RST asserted mid-set or mid-alarm SHALL abort the operation with no residual state; the first edge after release SHALL behave as RUN.

Verification
REQ-031 The bench SHALL check: reset, then 86400 TICKs -> wraps 23:59:59->00:00:00 exactly once, Alarm stays 0 (ALARM_EN=0).
REQ-032 The bench SHALL check: MODE_BTN at 10:20:30 -> Mode=1, Secs=0; 20 TICKs -> time unchanged; 15 INC_BTN -> Hours=1; MODE_BTN, 40 INC_BTN -> Mins=0, Hours=1.
REQ-033 The bench SHALL check: AlarmH=0, AlarmM=1, ALARM_EN=1 from 00:00:00, 60 TICKs -> Alarm=1 at 00:01:00; ALARM_LEN TICKs later -> Alarm=0.
REQ-034 The bench SHALL check: Alarm=1, INC_BTN in RUN -> Alarm=0 next edge, time unchanged; repeat with ALARM_EN dropped -> Alarm=0 next edge.
REQ-035 The bench SHALL check: MODE_BTN+INC_BTN same cycle in SET_H (Hours=5) -> Mode=2, Hours=5; TICK+INC_BTN in SET_AM -> Secs and AlarmM both advance.
REQ-036 The bench SHALL check: RST pulse mid-cycle in SET_M with Alarm=1 -> all outputs at reset values immediately, Mode=0.
